// File: rtl/demux_sched_pkg.sv
// Shared definitions for the demux slot scheduler.
// Holds channel/select/length widths, the FSM state type and the channel
// selection helpers used by the scheduler top level.
package demux_sched_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned LEN_W  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSlot,
    StGuard
  } state_e;

  // A channel is eligible when it is enabled and has a non-zero slot length.
  function automatic logic [NUM_CH-1:0] eligible_mask(input logic [NUM_CH-1:0]       mask,
                                                      input logic [NUM_CH*LEN_W-1:0] len);
    logic [NUM_CH-1:0] elig;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      elig[i] = mask[i] && (len[i*LEN_W +: LEN_W] != '0);
    end
    return elig;
  endfunction

  // Slot length field of one channel.
  function automatic logic [LEN_W-1:0] slot_len(input logic [NUM_CH*LEN_W-1:0] len,
                                                input logic [SEL_W-1:0]        idx);
    logic [LEN_W-1:0] l;
    l = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (idx == SEL_W'(i)) l = len[i*LEN_W +: LEN_W];
    end
    return l;
  endfunction

  // Lowest eligible index; 0 when nothing is eligible (caller checks |elig).
  function automatic logic [SEL_W-1:0] first_eligible(input logic [NUM_CH-1:0] elig);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (elig[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // Next eligible index above current. When none exists the walk wraps to the
  // lowest eligible index and wrap_flag_out is raised (a frame boundary).
  function automatic logic [SEL_W-1:0] next_eligible(input  logic [NUM_CH-1:0] mask,
                                                     input  logic [SEL_W-1:0]  current,
                                                     output logic              wrap_flag_out);
    logic [SEL_W-1:0] idx;
    logic             found;
    idx   = first_eligible(mask);
    found = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!found && mask[i] && (i > int'(current))) begin
        idx   = SEL_W'(i);
        found = 1'b1;
      end
    end
    wrap_flag_out = !found;
    return idx;
  endfunction

endpackage

// File: rtl/demux_sched_cfg_shadow.sv
// Double-buffered configuration for the demux slot scheduler.
// i_cfg_load captures mask/lengths into the pending set; i_apply (asserted by
// the scheduler at frame boundaries and while idle) promotes a valid pending
// set to active and pulses o_cfg_ack for one cycle.
// Ports:
//   i_clk, i_rst             clock, async active-high reset
//   i_cfg_load/mask/len      configuration capture strobe and data
//   i_apply                  promote pending to active if pending is valid
//   o_pend_valid/mask/len    pending configuration
//   o_act_mask/len           active configuration
//   o_cfg_ack                one-cycle pulse when pending became active
module demux_sched_cfg_shadow
  import demux_sched_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cfg_load,
  input  logic [NUM_CH-1:0]       i_cfg_mask,
  input  logic [NUM_CH*LEN_W-1:0] i_cfg_len,
  input  logic                    i_apply,
  output logic                    o_pend_valid,
  output logic [NUM_CH-1:0]       o_pend_mask,
  output logic [NUM_CH*LEN_W-1:0] o_pend_len,
  output logic [NUM_CH-1:0]       o_act_mask,
  output logic [NUM_CH*LEN_W-1:0] o_act_len,
  output logic                    o_cfg_ack
);

  logic                    r_pend_valid;
  logic [NUM_CH-1:0]       r_pend_mask;
  logic [NUM_CH*LEN_W-1:0] r_pend_len;
  logic [NUM_CH-1:0]       r_act_mask;
  logic [NUM_CH*LEN_W-1:0] r_act_len;
  logic                    r_cfg_ack;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend_valid <= 1'b0;
      r_pend_mask  <= '0;
      r_pend_len   <= '0;
      r_act_mask   <= '0;
      r_act_len    <= '0;
      r_cfg_ack    <= 1'b0;
    end else begin
      r_cfg_ack <= 1'b0;
      if (i_apply && r_pend_valid) begin
        r_act_mask   <= r_pend_mask;
        r_act_len    <= r_pend_len;
        r_cfg_ack    <= 1'b1;
        r_pend_valid <= 1'b0;
      end
      // A load in the same cycle as an apply wins pending: the old values were
      // just promoted and the new ones wait for the next boundary.
      if (i_cfg_load) begin
        r_pend_mask  <= i_cfg_mask;
        r_pend_len   <= i_cfg_len;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign o_pend_valid = r_pend_valid;
  assign o_pend_mask  = r_pend_mask;
  assign o_pend_len   = r_pend_len;
  assign o_act_mask   = r_act_mask;
  assign o_act_len    = r_act_len;
  assign o_cfg_ack    = r_cfg_ack;

endmodule

// File: rtl/demux_slot_scheduler.sv
// Time-division scheduler driving the select of a 4-way demultiplexer.
// Walks eligible channels in ascending order, one programmable-length slot
// each, separated by GUARD blank cycles. Config changes land only at frame
// boundaries (or while idle). All outputs are registered.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_enable            run request, honoured at slot boundaries
//   i_cfg_load          capture strobe for i_cfg_mask / i_cfg_len
//   o_cfg_ack           pulse when pending config becomes active
//   o_sel               demux select
//   o_slot_active       select valid (demux data gated when low)
//   o_slot_start        first cycle of every slot
//   o_frame_start       first cycle of the first slot of a frame
//   o_busy              FSM not idle
module demux_slot_scheduler
  import demux_sched_pkg::*;
#(
  parameter int unsigned GUARD = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_cfg_load,
  input  logic [NUM_CH-1:0]       i_cfg_mask,
  input  logic [NUM_CH*LEN_W-1:0] i_cfg_len,
  output logic                    o_cfg_ack,
  output logic [SEL_W-1:0]        o_sel,
  output logic                    o_slot_active,
  output logic                    o_slot_start,
  output logic                    o_frame_start,
  output logic                    o_busy
);

  localparam int unsigned GCW          = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam int unsigned GuardLoadInt = (GUARD > 0) ? GUARD - 1 : 0;
  localparam logic [GCW-1:0] GuardLoad = GuardLoadInt[GCW-1:0];

  state_e           r_state, w_state_d;
  logic [SEL_W-1:0] r_ch, w_ch_d;
  logic [LEN_W-1:0] r_cnt, w_cnt_d;
  logic [GCW-1:0]   r_gcnt, w_gcnt_d;
  logic             r_slot_active, r_slot_start, r_frame_start, r_busy;
  logic             w_slot_start_d, w_frame_start_d;

  logic                    w_apply;
  logic                    w_pend_valid;
  logic [NUM_CH-1:0]       w_pend_mask, w_act_mask;
  logic [NUM_CH*LEN_W-1:0] w_pend_len, w_act_len;
  logic [NUM_CH-1:0]       w_act_elig, w_eff_elig;
  logic [NUM_CH*LEN_W-1:0] w_eff_len;
  logic [SEL_W-1:0]        w_next_ch, w_first_ch;
  logic                    w_wrap, w_decide, w_launch_first;

  demux_sched_cfg_shadow u_cfg_shadow (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cfg_load   (i_cfg_load),
    .i_cfg_mask   (i_cfg_mask),
    .i_cfg_len    (i_cfg_len),
    .i_apply      (w_apply),
    .o_pend_valid (w_pend_valid),
    .o_pend_mask  (w_pend_mask),
    .o_pend_len   (w_pend_len),
    .o_act_mask   (w_act_mask),
    .o_act_len    (w_act_len),
    .o_cfg_ack    (o_cfg_ack)
  );

  // At a boundary the config that will be active after this edge decides the
  // first channel, so look through to pending when it is about to be applied.
  assign w_act_elig = eligible_mask(w_act_mask, w_act_len);
  assign w_eff_elig = w_pend_valid ? eligible_mask(w_pend_mask, w_pend_len) : w_act_elig;
  assign w_eff_len  = w_pend_valid ? w_pend_len : w_act_len;

  always_comb begin
    w_state_d       = r_state;
    w_ch_d          = r_ch;
    w_cnt_d         = r_cnt;
    w_gcnt_d        = r_gcnt;
    w_slot_start_d  = 1'b0;
    w_frame_start_d = 1'b0;
    w_apply         = 1'b0;
    w_decide        = 1'b0;
    w_launch_first  = 1'b0;
    w_wrap          = 1'b0;
    w_next_ch       = next_eligible(w_act_elig, r_ch, w_wrap);
    w_first_ch      = first_eligible(w_eff_elig);

    unique case (r_state)
      StIdle: begin
        w_apply = 1'b1;
        if (i_enable && (|w_eff_elig)) w_launch_first = 1'b1;
      end
      StSlot: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - LEN_W'(1);
        end else if (GUARD > 0) begin
          w_state_d = StGuard;
          w_gcnt_d  = GuardLoad;
        end else begin
          w_decide = 1'b1;
        end
      end
      StGuard: begin
        if (r_gcnt != '0) w_gcnt_d = r_gcnt - GCW'(1);
        else              w_decide = 1'b1;
      end
      default: w_state_d = StIdle;
    endcase

    // End of slot (and guard): stop, advance within the frame, or start a new frame.
    if (w_decide) begin
      if (!i_enable) begin
        w_state_d = StIdle;
      end else if (!w_wrap) begin
        w_state_d      = StSlot;
        w_ch_d         = w_next_ch;
        w_cnt_d        = slot_len(w_act_len, w_next_ch) - LEN_W'(1);
        w_slot_start_d = 1'b1;
      end else begin
        w_apply = 1'b1;
        if (|w_eff_elig) w_launch_first = 1'b1;
        else             w_state_d = StIdle;
      end
    end

    if (w_launch_first) begin
      w_state_d       = StSlot;
      w_ch_d          = w_first_ch;
      w_cnt_d         = slot_len(w_eff_len, w_first_ch) - LEN_W'(1);
      w_slot_start_d  = 1'b1;
      w_frame_start_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_ch          <= '0;
      r_cnt         <= '0;
      r_gcnt        <= '0;
      r_slot_active <= 1'b0;
      r_slot_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_ch          <= w_ch_d;
      r_cnt         <= w_cnt_d;
      r_gcnt        <= w_gcnt_d;
      r_slot_active <= (w_state_d == StSlot);
      r_slot_start  <= w_slot_start_d;
      r_frame_start <= w_frame_start_d;
      r_busy        <= (w_state_d != StIdle);
    end
  end

  assign o_sel         = r_ch;
  assign o_slot_active = r_slot_active;
  assign o_slot_start  = r_slot_start;
  assign o_frame_start = r_frame_start;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_demux_slot_scheduler.sv
// Directed bench for demux_slot_scheduler. Each check compares the packed
// output word {sel, slot_active, slot_start, frame_start, busy, cfg_ack}
// against a hand-computed value.
module tb_demux_slot_scheduler;
  import demux_sched_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    enable;
  logic                    cfg_load;
  logic [NUM_CH-1:0]       cfg_mask;
  logic [NUM_CH*LEN_W-1:0] cfg_len;
  logic                    cfg_ack;
  logic [SEL_W-1:0]        sel;
  logic                    slot_active;
  logic                    slot_start;
  logic                    frame_start;
  logic                    busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] frame_exp [0:14];

  demux_slot_scheduler #(
    .GUARD (1)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .i_cfg_load    (cfg_load),
    .i_cfg_mask    (cfg_mask),
    .i_cfg_len     (cfg_len),
    .o_cfg_ack     (cfg_ack),
    .o_sel         (sel),
    .o_slot_active (slot_active),
    .o_slot_start  (slot_start),
    .o_frame_start (frame_start),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {sel, slot_active, slot_start, frame_start, busy, cfg_ack};
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // {sel, act, ss, fs, busy, ack} for the 14-cycle frame with len {3,2,1,4}.
    frame_exp[0]  = 7'b00_1111_0;
    frame_exp[1]  = 7'b00_1001_0;
    frame_exp[2]  = 7'b00_1001_0;
    frame_exp[3]  = 7'b00_1001_0;
    frame_exp[4]  = 7'b00_0001_0;
    frame_exp[5]  = 7'b01_1101_0;
    frame_exp[6]  = 7'b01_0001_0;
    frame_exp[7]  = 7'b10_1101_0;
    frame_exp[8]  = 7'b10_1001_0;
    frame_exp[9]  = 7'b10_0001_0;
    frame_exp[10] = 7'b11_1101_0;
    frame_exp[11] = 7'b11_1001_0;
    frame_exp[12] = 7'b11_1001_0;
    frame_exp[13] = 7'b11_0001_0;
    frame_exp[14] = 7'b00_1111_0;

    rst      = 1'b1;
    enable   = 1'b0;
    cfg_load = 1'b0;
    cfg_mask = '0;
    cfg_len  = '0;
    #1;
    chk("reset", 7'b00_0000_0);
    step();
    step();
    rst = 1'b0;

    // Basic frame: config applied while idle, then run.
    cfg_load = 1'b1;
    cfg_mask = 4'b1111;
    cfg_len  = {8'd3, 8'd2, 8'd1, 8'd4};
    step();
    cfg_load = 1'b0;
    chk("idle_pending", 7'b00_0000_0);
    step();
    chk("idle_ack", 7'b00_0000_1);
    enable = 1'b1;
    step();
    chk("basic k0", frame_exp[0]);
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("basic k%0d", k), frame_exp[k]);
    end

    // Config swap mid-frame: current frame completes unchanged.
    cfg_load = 1'b1;
    cfg_mask = 4'b0001;
    cfg_len  = {8'd0, 8'd0, 8'd0, 8'd5};
    step();
    cfg_load = 1'b0;
    chk("swap k15", frame_exp[1]);
    for (int k = 16; k <= 27; k++) begin
      step();
      chk($sformatf("swap k%0d", k), frame_exp[k - 14]);
    end
    step();
    chk("swap boundary ack", 7'b00_1111_1);
    for (int k = 29; k <= 32; k++) begin
      step();
      chk($sformatf("swap len5 k%0d", k), 7'b00_1001_0);
    end
    step();
    chk("swap guard", 7'b00_0001_0);
    step();
    chk("swap single wrap", 7'b00_1111_0);

    // Two loads before the boundary: last one wins, single ack.
    cfg_load = 1'b1;
    cfg_len  = {8'd0, 8'd0, 8'd0, 8'd7};
    step();
    chk("reload1", 7'b00_1001_0);
    cfg_len = {8'd0, 8'd0, 8'd0, 8'd4};
    step();
    cfg_load = 1'b0;
    chk("reload2", 7'b00_1001_0);
    step();
    chk("reload3", 7'b00_1001_0);
    step();
    chk("reload4", 7'b00_1001_0);
    step();
    chk("reload guard", 7'b00_0001_0);
    step();
    chk("reload ack", 7'b00_1111_1);

    // Graceful disable in the second cycle of the 4-cycle slot.
    enable = 1'b0;
    step();
    chk("disable slot c2", 7'b00_1001_0);
    step();
    chk("disable slot c3", 7'b00_1001_0);
    step();
    chk("disable slot c4", 7'b00_1001_0);
    step();
    chk("disable guard", 7'b00_0001_0);
    step();
    chk("disable idle", 7'b00_0000_0);
    step();
    chk("disable stays idle", 7'b00_0000_0);

    // Empty config while enabled.
    cfg_load = 1'b1;
    cfg_mask = 4'b0000;
    cfg_len  = {8'd0, 8'd0, 8'd0, 8'd5};
    step();
    cfg_load = 1'b0;
    enable   = 1'b1;
    step();
    chk("empty ack", 7'b00_0000_1);
    step();
    chk("empty idle1", 7'b00_0000_0);
    step();
    chk("empty idle2", 7'b00_0000_0);

    // Skipping: only ch3 eligible (ch1 has zero length).
    cfg_load = 1'b1;
    cfg_mask = 4'b1010;
    cfg_len  = {8'd2, 8'd5, 8'd0, 8'd3};
    step();
    cfg_load = 1'b0;
    chk("skip pending", 7'b00_0000_0);
    step();
    chk("skip start", 7'b11_1111_1);
    step();
    chk("skip c2", 7'b11_1001_0);
    step();
    chk("skip guard", 7'b11_0001_0);
    step();
    chk("skip wrap fs", 7'b11_1111_0);
    step();
    chk("skip c2b", 7'b11_1001_0);

    // Asynchronous reset between edges, mid-slot.
    #2;
    rst = 1'b1;
    #1;
    chk("async reset", 7'b00_0000_0);
    step();
    chk("reset held", 7'b00_0000_0);
    rst      = 1'b0;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("restart pending", 7'b00_0000_0);
    step();
    chk("restart fs", 7'b11_1111_1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
